// File: rtl/lc3_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg
//   Shared types and helpers for the LC-3 branch-resolution block.
//   - br_state_e : BR sequencer states (idle / evaluate / respond)
//   - CC_*       : one-hot {N,Z,P} condition-code encodings, CC_RESET is Z
//   - sext_off() : sign-extends an off_w-bit offset held in the low bits of a
//                  32-bit word to the full 32 bits
// -----------------------------------------------------------------------------
package lc3_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEval = 2'd1,
        StResp = 2'd2
    } br_state_e;

    localparam logic [2:0] CC_N     = 3'b100;
    localparam logic [2:0] CC_Z     = 3'b010;
    localparam logic [2:0] CC_P     = 3'b001;
    localparam logic [2:0] CC_RESET = CC_Z;

    // Shift the offset's sign bit up to bit 31, then shift back arithmetically.
    function automatic logic [31:0] sext_off(input logic [31:0] off, input int unsigned off_w);
        int unsigned sh;
        sh = 32 - off_w;
        return $unsigned($signed(off << sh) >>> sh);
    endfunction

endpackage

// File: rtl/nzp_logic.sv
// -----------------------------------------------------------------------------
// nzp_logic
//   Classifies a bus value into a one-hot {N,Z,P} condition code.
//   Ports:
//     data_i  in   DATA_W  value being written to the register file
//     nzp_o   out  3       one-hot {N,Z,P}
// -----------------------------------------------------------------------------
module nzp_logic
    import lc3_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [2:0]        nzp_o
);

    always_comb begin
        nzp_o = CC_P;
        if (data_i[DATA_W-1]) begin
            nzp_o = CC_N;
        end else if (data_i == '0) begin
            nzp_o = CC_Z;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
//   LC-3 condition-code register and BR resolution sequencer.
//   Holds the {N,Z,P} register (loaded from the bus on ld_cc), accepts one BR
//   request at a time over br_valid/br_ready, evaluates it one cycle later and
//   presents taken/next-PC over res_valid/res_ready until consumed.
//   Ports:
//     Clk, Reset_n         clock (rising edge), async active-low reset
//     ld_cc, bus_data      load CC from bus value this cycle
//     br_valid/br_ready    request handshake; br_cond {n,z,p}, br_pc, br_off
//     res_valid/res_ready  result handshake; res_taken, res_pc
//     nzp_q                current condition-code register {N,Z,P}
// -----------------------------------------------------------------------------
module branch_ctrl
    import lc3_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OFF_W  = 9
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ld_cc,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [DATA_W-1:0] br_pc,
    input  logic [OFF_W-1:0]  br_off,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [DATA_W-1:0] res_pc,
    output logic [2:0]        nzp_q
);

    br_state_e         state_q, state_d;
    logic [2:0]        nzp_d;
    logic [2:0]        cc_new;
    logic [2:0]        cond_q, cond_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              res_taken_q, res_taken_d;
    logic [DATA_W-1:0] res_pc_q, res_pc_d;
    logic              taken;
    logic [DATA_W-1:0] target;

    nzp_logic #(
        .DATA_W(DATA_W)
    ) u_nzp_logic (
        .data_i(bus_data),
        .nzp_o (cc_new)
    );

    // CC loads in every state; a load during EVAL lands after the decision,
    // since the decision reads the register value of the current cycle.
    assign nzp_d = ld_cc ? cc_new : nzp_q;

    assign taken  = |(cond_q & nzp_q);
    // Target wraps modulo 2^DATA_W by truncation.
    assign target = pc_q + DATA_W'(sext_off(32'(off_q), OFF_W));

    always_comb begin
        state_d     = state_q;
        cond_d      = cond_q;
        pc_d        = pc_q;
        off_d       = off_q;
        res_taken_d = res_taken_q;
        res_pc_d    = res_pc_q;
        br_ready    = 1'b0;
        res_valid   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Hold off acceptance while the CC is being written so the
                // request is evaluated against the new flags.
                br_ready = !ld_cc;
                if (br_valid && !ld_cc) begin
                    cond_d  = br_cond;
                    pc_d    = br_pc;
                    off_d   = br_off;
                    state_d = StEval;
                end
            end
            StEval: begin
                res_taken_d = taken;
                res_pc_d    = taken ? target : pc_q;
                state_d     = StResp;
            end
            StResp: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            nzp_q       <= CC_RESET;
            cond_q      <= '0;
            pc_q        <= '0;
            off_q       <= '0;
            res_taken_q <= 1'b0;
            res_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            nzp_q       <= nzp_d;
            cond_q      <= cond_d;
            pc_q        <= pc_d;
            off_q       <= off_d;
            res_taken_q <= res_taken_d;
            res_pc_q    <= res_pc_d;
        end
    end

    assign res_taken = res_taken_q;
    assign res_pc    = res_pc_q;

    a_nzp_onehot: assert property (@(posedge Clk) disable iff (!Reset_n) $onehot(nzp_q));

    a_res_stable: assert property (@(posedge Clk) disable iff (!Reset_n)
        (res_valid && !res_ready) |=> (res_valid && $stable(res_pc) && $stable(res_taken)));

endmodule
